// File: rtl/button_debounce.sv
// button_debounce
//   Debounces N_BUT independent push-button inputs. Each channel goes through
//   polarity correction and a 2-flop synchroniser. A per-channel FSM then only
//   accepts a new level after it has been stable for DEBOUNCE_CYCLES cycles.
//
// Ports
//   clk         : system clock, all state on rising edge
//   rst         : asynchronous active-high reset
//   buttons_raw : raw asynchronous pins, bit i = channel i
//   buttons     : registered debounced level, 1 = pressed
//   pressed     : one-cycle pulse on debounced 0->1
//   released    : one-cycle pulse on debounced 1->0
//
// state        | meaning
// RELEASED     | debounced level 0, input agrees
// WAIT_PRESS   | debounced level 0, input has been 1 for cnt cycles
// PRESSED      | debounced level 1, input agrees
// WAIT_RELEASE | debounced level 1, input has been 0 for cnt cycles
module button_debounce #(
  parameter int N_BUT           = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BUT-1:0] buttons_raw,
  output logic [N_BUT-1:0] buttons,
  output logic [N_BUT-1:0] pressed,
  output logic [N_BUT-1:0] released
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  logic [N_BUT-1:0] raw_pol;
  logic [N_BUT-1:0] sync_1;
  logic [N_BUT-1:0] sync_2;

  // Polarity is fixed before synchronising so reset value 0 always means
  // "not pressed" regardless of pin polarity.
  assign raw_pol = (ACTIVE_LOW != 0) ? ~buttons_raw : buttons_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= raw_pol;
      sync_2 <= sync_1;
    end
  end

  for (genvar i = 0; i < N_BUT; i++) begin : g_ch
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          press_nxt;
    logic          rel_nxt;
    logic          btn_q;
    logic          press_q;
    logic          rel_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= RELEASED;
        cnt     <= '0;
        btn_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        btn_q   <= (state_nxt == PRESSED) || (state_nxt == WAIT_RELEASE);
        press_q <= press_nxt;
        rel_q   <= rel_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      press_nxt = 1'b0;
      rel_nxt   = 1'b0;
      case (state)
        RELEASED: begin
          if (sync_2[i]) begin
            state_nxt = WAIT_PRESS;
            cnt_nxt   = CW'(1);
          end else begin
            cnt_nxt   = '0;
          end
        end
        WAIT_PRESS: begin
          if (!sync_2[i]) begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt   = cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!sync_2[i]) begin
            state_nxt = WAIT_RELEASE;
            cnt_nxt   = CW'(1);
          end else begin
            cnt_nxt   = '0;
          end
        end
        WAIT_RELEASE: begin
          if (sync_2[i]) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
            rel_nxt   = 1'b1;
          end else begin
            cnt_nxt   = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign buttons[i]  = btn_q;
    assign pressed[i]  = press_q;
    assign released[i] = rel_q;
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce with DEBOUNCE_CYCLES=4, N_BUT=2. Two instances
// (active-high pins and active-low pins fed the inverted pattern) must show
// identical outputs. Expected values come from a fixed vector table, a few
// hand-written sequences and a run-length reference model.
module tb_button_debounce;

  localparam int D = 4;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] raw = '0;
  logic [N-1:0] raw_n;
  logic [N-1:0] b0, p0, r0, b1, p1, r1;

  assign raw_n = ~raw;

  always #5 clk = ~clk;

  button_debounce #(.N_BUT(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(0)) dut_hi (
    .clk(clk), .rst(rst), .buttons_raw(raw),
    .buttons(b0), .pressed(p0), .released(r0));

  button_debounce #(.N_BUT(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1)) dut_lo (
    .clk(clk), .rst(rst), .buttons_raw(raw_n),
    .buttons(b1), .pressed(p1), .released(r1));

  int total = 0;
  int bad   = 0;

  // reference model: raw delayed two edges, level flips after D consecutive
  // disagreeing samples
  logic [N-1:0] m_s1, m_s2, m_lvl, m_p, m_r;
  int           m_run [N];

  typedef struct {
    logic [N-1:0] raw;
    logic [5:0]   exp;   // {buttons, pressed, released}
  } vec_t;
  vec_t tbl[$];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_p = '0; m_r = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      m_p[i] = 1'b0;
      m_r[i] = 1'b0;
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == D) begin
          m_lvl[i] = m_s2[i];
          m_p[i]   = m_s2[i];
          m_r[i]   = ~m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got b/p/r=%b expected %b at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_both(input string name, input logic [5:0] exp);
    check({name, "_hi"}, {b0, p0, r0}, exp);
    check({name, "_lo"}, {b1, p1, r1}, exp);
  endtask

  // drive at falling edge, advance one rising edge, compare at next falling edge
  task automatic cycle(input logic [N-1:0] r);
    raw = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_both("model", {m_lvl, m_p, m_r});
    if ((p0 & r0) != '0) begin
      total++; bad++;
      $display("FAIL pulse_overlap: pressed=%b released=%b", p0, r0);
    end
  endtask

  function automatic void push(input logic [N-1:0] r, input logic [1:0] eb,
                               input logic [1:0] ep, input logic [1:0] er);
    vec_t v;
    v.raw = r;
    v.exp = {eb, ep, er};
    tbl.push_back(v);
  endfunction

  initial begin
    model_reset();
    // clean press ch0, then ch1, then simultaneous release, then short glitch
    for (int k = 1; k <= 7; k++)
      push(2'b01, (k >= 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00, 2'b00);
    for (int k = 1; k <= 7; k++)
      push(2'b11, (k >= 6) ? 2'b11 : 2'b01, (k == 6) ? 2'b10 : 2'b00, 2'b00);
    for (int k = 1; k <= 7; k++)
      push(2'b00, (k >= 6) ? 2'b00 : 2'b11, 2'b00, (k == 6) ? 2'b11 : 2'b00);
    for (int k = 1; k <= 9; k++)
      push((k <= 3) ? 2'b10 : 2'b00, 2'b00, 2'b00, 2'b00);

    repeat (3) @(negedge clk);
    check_both("reset_state", 6'b0);
    rst = 1'b0;

    foreach (tbl[j]) begin
      cycle(tbl[j].raw);
      check_both($sformatf("table_%0d", j), tbl[j].exp);
    end

    // bounce: 1,0,1,0 then hold 1; press lands on the 6th edge of the hold
    cycle(2'b01); cycle(2'b00); cycle(2'b01); cycle(2'b00);
    check_both("bounce_quiet", 6'b0);
    for (int k = 1; k <= 7; k++) begin
      cycle(2'b01);
      check_both($sformatf("bounce_hold_%0d", k),
                 {(k >= 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00, 2'b00});
    end

    // reset in the middle of a release count: immediate clear, no release pulse
    repeat (3) cycle(2'b00);
    check_both("pre_reset_held", 6'b01_00_00);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_both("rst_async", 6'b0);
    @(negedge clk);
    cycle(2'b01);
    cycle(2'b01);
    check_both("rst_held", 6'b0);
    rst = 1'b0;
    // raw held through reset deassertion: normal press at edge 6
    for (int k = 1; k <= 7; k++) begin
      cycle(2'b01);
      check_both($sformatf("post_rst_%0d", k),
                 {(k >= 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00, 2'b00});
    end

    // randomized levels with occasional toggles, checked against the model
    begin
      logic [N-1:0] r;
      r = raw;
      for (int k = 0; k < 600; k++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 4) == 0) r[i] = ~r[i];
        cycle(r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter N_BUT, default 2, giving the number of independent button channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the stable-cycle count: 10 ms at 100 MHz; legal range 2 to 2^24.
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 0; 1 means a raw pin low is "pressed".
REQ-004 The block SHALL have port clk, input, 1 bit: 100 MHz clock; all state SHALL be clocked on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port buttons_raw, input, N_BUT bits: asynchronous raw pins (BUT); bit i is channel i.
REQ-007 The block SHALL have port buttons, output, N_BUT bits: debounced level, 1 = pressed; feeds the downstream button/LED stage.
REQ-008 The block SHALL have port pressed, output, N_BUT bits: one-cycle pulse on a debounced 0->1 transition.
REQ-009 The block SHALL have port released, output, N_BUT bits: one-cycle pulse on a debounced 1->0 transition.

Function
REQ-010 Each channel SHALL pass buttons_raw[i] through a 2-flop synchroniser, after polarity correction per ACTIVE_LOW, before any other logic.
REQ-011 Each channel SHALL hold a counter of width clog2(DEBOUNCE_CYCLES)+1 bits and a 4-state FSM: RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE.
REQ-012 RELEASED: sync=1 -> WAIT_PRESS with counter=1; otherwise stay with counter=0.
REQ-013 WAIT_PRESS: sync=0 -> RELEASED with counter=0, and no pulse; sync=1 and counter=DEBOUNCE_CYCLES-1 -> PRESSED; otherwise counter+1.
REQ-014 PRESSED and WAIT_RELEASE SHALL behave as the mirror of REQ-012 and REQ-013 with sync polarity inverted.
REQ-015 buttons[i] SHALL be 1 exactly in states PRESSED and WAIT_RELEASE, and SHALL be registered.
REQ-016 pressed[i] SHALL be asserted for exactly one cycle, in the same cycle that buttons[i] first reads 1; released[i] SHALL behave likewise for the first cycle buttons[i] reads 0.
REQ-017 Latency: with a raw level held stable, buttons[i] SHALL change exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples the new raw value.
REQ-018 Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL produce no change on buttons, pressed or released, and SHALL restart the count from zero.
REQ-019 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-020 pressed[i] and released[i] SHALL never be asserted in the same cycle; consecutive pulses on one channel SHALL be at least DEBOUNCE_CYCLES cycles apart.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL produce simultaneous, independent pulses.

Reset
REQ-022 While rst=1, the synchroniser flops SHALL hold 0 (not pressed), every FSM SHALL be in RELEASED, every counter SHALL be 0, and buttons, pressed and released SHALL be all 0.
REQ-023 Reset assertion SHALL take effect immediately, without a clock edge, including mid-count, and SHALL produce no released pulse.
REQ-024 If a button is held through reset deassertion, the block SHALL produce a normal press (buttons=1 plus a pressed pulse) 2+DEBOUNCE_CYCLES edges after the first post-reset edge.

Verification (DEBOUNCE_CYCLES=4, N_BUT=2, ACTIVE_LOW=0)
REQ-025 Clean press: buttons_raw 00->01 held -> buttons=01 and pressed=01 for one cycle at edge 6; released stays 00.
REQ-026 Bounce: buttons_raw[0] toggles 1,0,1,0 at 1-cycle spacing then holds 1 -> no output change during the bounce; buttons[0]=1 six edges after the final rise.
REQ-027 Release and simultaneous channels: from buttons=11, buttons_raw->00 -> released=11 pulse for one cycle at edge 6, then buttons=00.
REQ-028 Sub-threshold glitch: buttons_raw[1]=1 for 3 cycles then 0 -> buttons, pressed and released stay 00 throughout.
REQ-029 Reset mid-count: rst pulse asynchronously during WAIT_PRESS -> outputs stay 0 at once; with raw held, pressed pulse at edge 6 after reset release.
REQ-030 ACTIVE_LOW=1 rerun of REQ-025 with buttons_raw 11->10 -> identical output waveform.
